prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 192 +++++++++++++++++++
 tb/tb_prog_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: assembles a byte stream into memory words while holding the system in reset.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum word after EndWord.
module prog_loader #(
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          AddrWidth   = 12,
  parameter logic [DataWidth-1:0] EndWord     = '1,
  parameter int unsigned          ByteTimeout = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 prog_i,
  input  logic                 rx_dv_i,
  input  logic [7:0]           rx_byte_i,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic                 prog_rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [1:0] StCheck = 2'd2;
`endif
  localparam logic [1:0] StErr   = 2'd3;

  localparam int unsigned          NumBytes = DataWidth / 8;
  localparam logic [3:0]           LastByte = 4'(NumBytes - 1);
  localparam logic [AddrWidth-1:0] LastAddr = '1;
  localparam logic [31:0]          TmoLast  = 32'(ByteTimeout - 1);

  logic [1:0]           state_q, state_d;
  logic                 prog_q;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DataWidth-1:0] word_q, word_d;
  logic [31:0]          tmo_q, tmo_d;
  logic                 full_q, full_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DataWidth-1:0] sum_q, sum_d;
`endif

  logic                 rise;
  logic                 last_byte;
  logic                 ovf;
  logic [DataWidth-1:0] asm_w;

  assign rise      = prog_i & ~prog_q;
  assign last_byte = (bcnt_q == LastByte);
  // The write to the last address may still be in flight in this cycle
  assign ovf       = full_q | (we_q & (addr_q == LastAddr));
  // Little-endian: each byte enters at the top and shifts down
  assign asm_w     = DataWidth'({rx_byte_i, word_q} >> 8);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    full_d  = full_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (we_q) begin
      addr_d = addr_q + AddrWidth'(1);
      if (addr_q == LastAddr) full_d = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StLoad;
          addr_d  = '0;
          bcnt_d  = '0;
          tmo_d   = '0;
          full_d  = 1'b0;
          err_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLoad
`ifdef PROG_LOADER_CHECKSUM_EN
      , StCheck
`endif
      : begin
        if (rx_dv_i) begin
          tmo_d  = '0;
          word_d = asm_w;
          bcnt_d = last_byte ? 4'd0 : bcnt_q + 4'd1;
          if (last_byte) begin
            if (state_q == StLoad) begin
              if (asm_w == EndWord) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state_d = StCheck;
`else
                state_d = StIdle;
                done_d  = 1'b1;
`endif
              end else if (ovf) begin
                state_d = StErr;
                err_d   = 1'b1;
              end else begin
                we_d    = 1'b1;
                wdata_d = asm_w;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_d   = sum_q + asm_w;
`endif
              end
            end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
              if (asm_w == sum_q) begin
                state_d = StIdle;
                done_d  = 1'b1;
              end else begin
                state_d = StErr;
                err_d   = 1'b1;
              end
`endif
            end
          end
        end else if (bcnt_q != 4'd0) begin
          if (tmo_q == TmoLast) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
      end
      StErr: begin
        if (rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      prog_q  <= 1'b0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      prog_q  <= prog_i;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      full_q  <= full_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign prog_rst_no = (state_q == StIdle);
  assign busy_o      = (state_q == StLoad);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader.
// Two instances: 32-bit words with short timeout, and 16-bit words with 4-word memory.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        prog_a, dv_a, prog_b, dv_b;
  logic [7:0]  rb_a, rb_b;
  logic        we_a, prst_a, busy_a, done_a, err_a;
  logic [11:0] addr_a;
  logic [31:0] wd_a;
  logic        we_b, prst_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [15:0] wd_b;

  int n_chk = 0;
  int n_fail = 0;
  int done_a_cnt = 0;
  int done_b_cnt = 0;
  logic [43:0] qa[$];
  logic [17:0] qb[$];
  logic [43:0] exp_a;
  logic [17:0] exp_b;

  prog_loader #(.DataWidth(32), .AddrWidth(12), .ByteTimeout(10)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .prog_i(prog_a), .rx_dv_i(dv_a),
    .rx_byte_i(rb_a), .we_o(we_a), .addr_o(addr_a), .wdata_o(wd_a),
    .prog_rst_no(prst_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
  );

  prog_loader #(.DataWidth(16), .AddrWidth(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .prog_i(prog_b), .rx_dv_i(dv_b),
    .rx_byte_i(rb_b), .we_o(we_b), .addr_o(addr_b), .wdata_o(wd_b),
    .prog_rst_no(prst_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
  );

  // Write monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (done_a) done_a_cnt++;
    if (done_b) done_b_cnt++;
    if (we_a) begin
      n_chk++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL wr_a: unexpected write %0h@%0h", wd_a, addr_a);
      end else begin
        exp_a = qa.pop_front();
        if ({addr_a, wd_a} !== exp_a) begin
          n_fail++;
          $display("FAIL wr_a: got %0h@%0h want %0h@%0h",
                   wd_a, addr_a, exp_a[31:0], exp_a[43:32]);
        end
      end
    end
    if (we_b) begin
      n_chk++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL wr_b: unexpected write %0h@%0h", wd_b, addr_b);
      end else begin
        exp_b = qb.pop_front();
        if ({addr_b, wd_b} !== exp_b) begin
          n_fail++;
          $display("FAIL wr_b: got %0h@%0h want %0h@%0h",
                   wd_b, addr_b, exp_b[15:0], exp_b[17:16]);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    dv_a = 1'b1;
    rb_a = b;
    tick();
    dv_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    dv_b = 1'b1;
    rb_b = b;
    tick();
    dv_b = 1'b0;
  endtask

  task automatic word_a(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_a(w[8*i +: 8]);
  endtask

  task automatic word_b(input logic [15:0] w);
    for (int i = 0; i < 2; i++) send_b(w[8*i +: 8]);
  endtask

  task automatic finish_a(input logic [31:0] sum);
    word_a(32'hFFFF_FFFF);
`ifdef PROG_LOADER_CHECKSUM_EN
    word_a(sum);
`else
    $display("load closed, word sum %08h", sum);
`endif
  endtask

  task automatic start_a;
    int k;
    prog_a = 1'b0;
    tick(2);
    prog_a = 1'b1;
    k = 0;
    while (busy_a !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    n_chk++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL start_a: busy=%b want 1", busy_a);
    end
  endtask

  task automatic start_b;
    int k;
    prog_b = 1'b0;
    tick(2);
    prog_b = 1'b1;
    k = 0;
    while (busy_b !== 1'b1 && k < 8) begin
      tick();
      k++;
    end
    n_chk++;
    if (busy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL start_b: busy=%b want 1", busy_b);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    prog_a = 1'b0; dv_a = 1'b0; rb_a = 8'h00;
    prog_b = 1'b0; dv_b = 1'b0; rb_b = 8'h00;
    #2;
    n_chk++;
    if ({we_a, addr_a, wd_a, prst_a, busy_a, done_a, err_a} !==
        {1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: we=%b a=%0h d=%0h rst_n=%b busy=%b done=%b err=%b",
               we_a, addr_a, wd_a, prst_a, busy_a, done_a, err_a);
    end
    n_chk++;
    if ({we_b, addr_b, wd_b, prst_b, busy_b, done_b, err_b} !==
        {1'b0, 2'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b: we=%b a=%0h d=%0h rst_n=%b busy=%b done=%b err=%b",
               we_b, addr_b, wd_b, prst_b, busy_b, done_b, err_b);
    end
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_load;
    int d0;
    d0 = done_a_cnt;
    start_a;
    prog_a = 1'b0;
    qa.push_back({12'h000, 32'h1234_5678});
    qa.push_back({12'h001, 32'hDEAD_BEEF});
    n_chk++;
    if (prst_a !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: prog_rst_no=%b want 0", prst_a);
    end
    word_a(32'h1234_5678);
    word_a(32'hDEAD_BEEF);
    n_chk++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_prog_drop: busy=%b want 1", busy_a);
    end
    finish_a(32'h1234_5678 + 32'hDEAD_BEEF);
    tick(3);
    n_chk++;
    if (done_a_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL basic_done: pulses=%0d want 1", done_a_cnt - d0);
    end
    n_chk++;
    if ({prst_a, busy_a, err_a} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_idle: rst_n/busy/err=%b want 100", {prst_a, busy_a, err_a});
    end
    n_chk++;
    if (qa.size() !== 0) begin
      n_fail++;
      $display("FAIL basic_writes: %0d missing want 0", qa.size());
    end
  endtask

  task automatic test_overflow;
    int d0;
    d0 = done_b_cnt;
    start_b;
    for (int i = 0; i < 4; i++) qb.push_back({2'(i), 16'h1000 + 16'(i)});
    for (int i = 0; i < 5; i++) word_b(16'h1000 + 16'(i));
    tick(3);
    n_chk++;
    if ({err_b, prst_b, busy_b} !== 3'b100) begin
      n_fail++;
      $display("FAIL ovf_state: err/rst_n/busy=%b want 100", {err_b, prst_b, busy_b});
    end
    n_chk++;
    if (qb.size() !== 0 || done_b_cnt !== d0) begin
      n_fail++;
      $display("FAIL ovf_writes: missing=%0d done=%0d want 0/0",
               qb.size(), done_b_cnt - d0);
    end
  endtask

  task automatic test_timeout;
    int d0;
    start_a;
    tick(20);
    n_chk++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_boundary: busy=%b want 1", busy_a);
    end
    send_a(8'hAA);
    send_a(8'hBB);
    tick(9);
    n_chk++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_early: busy=%b want 1", busy_a);
    end
    tick(2);
    n_chk++;
    if ({err_a, busy_a, prst_a} !== 3'b100) begin
      n_fail++;
      $display("FAIL tmo_err: err/busy/rst_n=%b want 100", {err_a, busy_a, prst_a});
    end
    prog_a = 1'b0;
    tick(2);
    prog_a = 1'b1;
    tick(3);
    n_chk++;
    if ({prst_a, err_a} !== 2'b11) begin
      n_fail++;
      $display("FAIL tmo_idle: rst_n/err=%b want 11", {prst_a, err_a});
    end
    start_a;
    n_chk++;
    if (err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: err=%b want 0", err_a);
    end
    d0 = done_a_cnt;
    qa.push_back({12'h000, 32'h0BAD_F00D});
    word_a(32'h0BAD_F00D);
    finish_a(32'h0BAD_F00D);
    tick(3);
    n_chk++;
    if (done_a_cnt - d0 !== 1 || qa.size() !== 0) begin
      n_fail++;
      $display("FAIL tmo_reload: done=%0d missing=%0d want 1/0",
               done_a_cnt - d0, qa.size());
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    start_a;
    send_a(8'h11);
    send_a(8'h22);
    send_a(8'h33);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({we_a, addr_a, wd_a, prst_a, busy_a, done_a, err_a} !==
        {1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_a: we=%b a=%0h d=%0h rst_n=%b busy=%b done=%b err=%b",
               we_a, addr_a, wd_a, prst_a, busy_a, done_a, err_a);
    end
    n_chk++;
    if ({err_b, prst_b} !== 2'b01) begin
      n_fail++;
      $display("FAIL midrst_b: err/rst_n=%b want 01", {err_b, prst_b});
    end
    tick();
    rst_n = 1'b1;
    tick();
    d0 = done_a_cnt;
    start_a;
    qa.push_back({12'h000, 32'h0403_0201});
    word_a(32'h0403_0201);
    finish_a(32'h0403_0201);
    tick(3);
    n_chk++;
    if (done_a_cnt - d0 !== 1 || qa.size() !== 0) begin
      n_fail++;
      $display("FAIL midrst_reload: done=%0d missing=%0d want 1/0",
               done_a_cnt - d0, qa.size());
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int d0;
    d0 = done_a_cnt;
    start_a;
    qa.push_back({12'h000, 32'd1});
    qa.push_back({12'h001, 32'd2});
    word_a(32'd1);
    word_a(32'd2);
    word_a(32'hFFFF_FFFF);
    word_a(32'd3);
    tick(3);
    n_chk++;
    if (done_a_cnt - d0 !== 1 || err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_good: done=%0d err=%b want 1/0", done_a_cnt - d0, err_a);
    end
    d0 = done_a_cnt;
    start_a;
    qa.push_back({12'h000, 32'd1});
    qa.push_back({12'h001, 32'd2});
    word_a(32'd1);
    word_a(32'd2);
    word_a(32'hFFFF_FFFF);
    word_a(32'd4);
    tick(3);
    n_chk++;
    if (done_a_cnt - d0 !== 0 || {err_a, prst_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL csum_bad: done=%0d err/rst_n=%b want 0/10",
               done_a_cnt - d0, {err_a, prst_a});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_overflow();
    test_timeout();
    test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    n_chk++;
    if (qa.size() !== 0 || qb.size() !== 0) begin
      n_fail++;
      $display("FAIL final_queues: a=%0d b=%0d want 0/0", qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
